ifetch_sequencer: RTL
=====================

Name: ifetch_sequencer

Overview:
- Instruction fetch and PC sequencer; the producing end of the decode/control interface.
- Fetches each instruction from instruction memory over a req/ack handshake and presents it to decode/control.
- Holds it until the datapath retires it, then consumes the control unit's Pcsrc/Imm result to select the next PC.
- Turns the single-cycle core into a handshaked fetch loop that tolerates variable memory latency.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- TIMEOUT, 16, max cycles FETCH waits for Imem_ack (used only with the optional feature).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Clrn  in  1  asynchronous active-low reset.
- Imem_req  out  1  fetch request to instruction memory.
- Imem_addr  out  32  fetch address (= Pc).
- Imem_ack  in  1  memory has valid Imem_rdata this cycle.
- Imem_rdata  in  32  fetched instruction word.
- Inst  out  32  registered instruction to decode (Op=Inst[31:26], Func=Inst[5:0]).
- Inst_valid  out  1  Inst is valid and held.
- Inst_ready  in  1  datapath retires Inst this cycle; Pcsrc/Imm sampled now.
- Pcsrc  in  2  next-PC select from control: 00 PC+4, 01 branch, 1x jump.
- Imm  in  32  sign-extended branch offset (word units).
- Pc  out  32  address of current instruction.
- Pc4  out  32  Pc+4.
- Fetch_err  out  1  sticky fetch timeout flag (optional feature only; else tied 0).

Behaviour:
- States: FETCH, ISSUE (plus ERROR with the optional feature).
- Reset (async, Clrn=0) sets:
  - state=FETCH, Pc=RESET_PC, Inst=0, Inst_valid=0, Fetch_err=0.
  - Imem_req is 1 in FETCH, so it is 1 immediately after reset.
- FETCH:
  - Imem_req=1, Imem_addr=Pc held stable, Inst_valid=0.
  - On Imem_ack=1: Inst<=Imem_rdata, go to ISSUE. Ack in the same cycle as first request is legal, giving a 1-cycle fetch.
- ISSUE:
  - Imem_req=0, Inst_valid=1, Inst stable.
  - Imem_ack in ISSUE is ignored.
  - On Inst_ready=1: Pc<=next_pc, go to FETCH.
  - Inst_ready in FETCH is ignored.
- next_pc, computed combinationally from the current Pc/Inst:
  - Pcsrc=00: Pc4.
  - Pcsrc=01: Pc4 + (Imm<<2).
  - Pcsrc=10 or 11: {Pc4[31:28], Inst[25:0], 2'b00}; jump dominates.
- Arithmetic: all adds are 32-bit modulo 2^32 with no overflow flag. 32'hFFFF_FFFC + 4 = 0.
- Alignment: Pc[1:0] is always 00, by construction.
- Throughput: minimum 2 cycles per instruction (1 FETCH + 1 ISSUE).
- Reset mid-fetch or mid-issue: the outstanding request is abandoned. Memory must tolerate Imem_req dropping without an ack.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to FETCH and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, go to ERROR: Fetch_err=1 (sticky), Imem_req=0, Inst_valid=0.
  - ERROR is left only by reset.
  - Ack in the same cycle as the terminal count wins: go to ISSUE, no error.
- Without the macro: no counter, no ERROR state, Fetch_err tied 0, FETCH waits indefinitely.

Decomposition:
- Shared package cpu_pkg holds:
  - Pcsrc encodings PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_J=2'b10.
  - Fetch state enum.
  - Instruction field positions (OP_MSB/LSB, FUNC_MSB/LSB, JIDX width).
  - Default reset PC constant.
- One sub-module: ifetch_npc, the combinational next-PC adder/mux (Pc, Inst, Imm, Pcsrc -> Pc4, next_pc).

Test Plan:
- Reset with Clrn low for 3 cycles, then release -> Pc=0, Imem_req=1 and Imem_addr=0 immediately; Inst_valid=0 throughout reset.
- Immediate ack, rdata 32'h2001_0005; Inst_ready with Pcsrc=00 one cycle later -> Inst=32'h2001_0005, Inst_valid for 1 cycle, next Imem_addr=4.
- Branch: Pc=32'h10, Imm=32'hFFFF_FFFE, Pcsrc=01 at retire -> next Pc=32'h0C. Jump: Pc=32'h40, Inst=32'h0800_0100, Pcsrc=10 -> next Pc=32'h400.
- Ack delayed 5 cycles; Inst_ready held low 3 cycles in ISSUE; spurious ack in ISSUE -> Imem_addr stable during wait, Inst unchanged, single PC advance only.
- Wrap: RESET_PC=32'hFFFF_FFFC, Pcsrc=00 at retire -> next Imem_addr=0. Async reset asserted mid-wait -> outputs reset without a clock edge.
- With IFETCH_TIMEOUT_EN and TIMEOUT=16, no ack -> Fetch_err=1 after 16 FETCH cycles, Imem_req=0, held until reset. Ack on cycle 16 -> no error.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states,
// instruction field positions and the default reset PC.
package cpu_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;
  localparam int JIDX_W   = 26;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ERROR = 2'd2
  } fetch_state_e;

  function automatic logic [OP_MSB-OP_LSB:0] inst_op(input logic [31:0] inst);
    return inst[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [FUNC_MSB-FUNC_LSB:0] inst_func(input logic [31:0] inst);
    return inst[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

// File: rtl/ifetch_npc.sv
// Combinational next-PC logic: PC+4, word-offset branch target and
// pseudo-direct jump target, selected by the control unit's Pcsrc.
module ifetch_npc
  import cpu_pkg::*;
(
  input  logic [31:0]       pc_i,
  input  logic [JIDX_W-1:0] jidx_i,
  input  logic [31:0]       imm_i,
  input  logic [1:0]        pcsrc_i,
  output logic [31:0]       pc4_o,
  output logic [31:0]       next_pc_o
);

  logic [31:0] br_target;
  logic [31:0] j_target;

  // All adds wrap modulo 2^32; there is deliberately no overflow detection.
  assign pc4_o     = pc_i + 32'd4;
  assign br_target = pc4_o + (imm_i << 2);
  assign j_target  = {pc4_o[31:28], jidx_i, 2'b00};

  always_comb begin
    case (pcsrc_i)
      PCSRC_SEQ: next_pc_o = pc4_o;
      PCSRC_BR:  next_pc_o = br_target;
      default:   next_pc_o = j_target;
    endcase
  end

endmodule

// File: rtl/ifetch_sequencer.sv
// Instruction fetch / PC sequencer: req/ack fetch from imem, hold Inst for
// decode until retired. Optional fetch timeout under `IFETCH_TIMEOUT_EN.
module ifetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC
`ifdef IFETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic        Clk,
  input  logic        Clrn,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Inst,
  output logic        Inst_valid,
  input  logic        Inst_ready,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Imm,
  output logic [31:0] Pc,
  output logic [31:0] Pc4,
  output logic        Fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  next_pc;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  ifetch_npc u_npc (
    .pc_i      (pc_q),
    .jidx_i    (inst_q[JIDX_W-1:0]),
    .imm_i     (Imm),
    .pcsrc_i   (Pcsrc),
    .pc4_o     (Pc4),
    .next_pc_o (next_pc)
  );

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through the block leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    Imem_req   = 1'b0;
    Inst_valid = 1'b0;
    Fetch_err  = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    cnt_d      = '0;
`endif
    case (state_q)
      ST_FETCH: begin
        Imem_req = 1'b1;
        if (Imem_ack) begin
          inst_d  = Imem_rdata;
          state_d = ST_ISSUE;
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_ISSUE: begin
        Inst_valid = 1'b1;
        if (Inst_ready) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
`ifdef IFETCH_TIMEOUT_EN
      // Terminal state: only Clrn brings the fetcher back.
      ST_ERROR: Fetch_err = 1'b1;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= ST_FETCH;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign Imem_addr = pc_q;
  assign Pc        = pc_q;
  assign Inst      = inst_q;

endmodule
